// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the buffered UART echo engine
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } uart_rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } uart_tx_state_e;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_echo_buffered_if.sv
// rtl/uart_echo_buffered_if.sv - serial lines, control and status bundle of the echo engine
interface uart_echo_buffered_if
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
);
    logic                          rx_serial;
    logic                          tx_serial;
    logic                          tx_hold;
    logic                          clr_status;
    logic [UART_DATA_BITS-1:0]     last_byte;
    logic [CNT_W-1:0]              rx_count;
    logic [$clog2(DEPTH):0]        fifo_level;
    logic                          overflow;
    logic                          frame_err;
    logic                          parity_err;

    modport master (
        output rx_serial, tx_hold, clr_status,
        input  tx_serial, last_byte, rx_count, fifo_level, overflow, frame_err, parity_err
    );

    modport slave (
        input  rx_serial, tx_hold, clr_status,
        output tx_serial, last_byte, rx_count, fifo_level, overflow, frame_err, parity_err
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock first-word-fall-through FIFO with occupancy output
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/uart_echo_buffered.sv
// rtl/uart_echo_buffered.sv - UART RX -> FIFO -> TX echo with hold, sticky flags and byte counter
// Optional even parity on both directions: UART_ECHO_PARITY_EN
module uart_echo_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH        = 16,
    parameter int CNT_W        = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    uart_echo_buffered_if.slave io
);
`ifdef UART_ECHO_PARITY_EN
    localparam int NB = UART_DATA_BITS + 1;
`else
    localparam int NB = UART_DATA_BITS;
`endif
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(NB);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NB - 1);

    logic rx_meta, rx_sync;

    uart_rx_state_e rx_state, rx_state_n;
    logic [CW-1:0]  rx_cnt, rx_cnt_n;
    logic [IW-1:0]  rx_idx, rx_idx_n;
    logic [NB-1:0]  rx_sh, rx_sh_n;
    logic           rx_push, frame_set;

    uart_tx_state_e tx_state, tx_state_n;
    logic [CW-1:0]  tx_cnt, tx_cnt_n;
    logic [IW-1:0]  tx_idx, tx_idx_n;
    logic [NB-1:0]  tx_sh, tx_sh_n, tx_load;
    logic           tx_pop, tx_line, tx_line_n, tx_start_ok;

    logic [UART_DATA_BITS-1:0] fifo_rdata;
    logic                      fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0]    fifo_level;

    logic [UART_DATA_BITS-1:0] last_byte;
    logic [CNT_W-1:0]          rx_count;
    logic                      overflow, frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= io.rx_serial;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx_line  <= 1'b1;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_sh    <= rx_sh_n;
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_sh    <= tx_sh_n;
            tx_line  <= tx_line_n;
        end
    end

`ifdef UART_ECHO_PARITY_EN
    logic parity_set, parity_err;
`endif

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_sh_n    = rx_sh;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
`ifdef UART_ECHO_PARITY_EN
        parity_set = 1'b0;
`endif
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (!rx_sync) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_idx_n   = '0;
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end else rx_cnt_n = rx_cnt + 1'b1;
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
                    rx_sh_n  = {rx_sync, rx_sh[NB-1:1]};
                    if (rx_idx == IDX_LAST) rx_state_n = RX_STOP;
                    else rx_idx_n = rx_idx + 1'b1;
                end else rx_cnt_n = rx_cnt + 1'b1;
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
`ifdef UART_ECHO_PARITY_EN
                    parity_set = ^rx_sh;
                    rx_push    = rx_sync && !(^rx_sh);
`else
                    rx_push    = rx_sync;
`endif
                    frame_set  = !rx_sync;
                    // A low stop bit may be a break; wait for the line to recover before re-arming.
                    rx_state_n = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
                end else rx_cnt_n = rx_cnt + 1'b1;
            end
            RX_WAIT_HIGH: begin
                if (rx_sync) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .wdata (rx_sh[UART_DATA_BITS-1:0]),
        .pop   (tx_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef UART_ECHO_PARITY_EN
    assign tx_load = {even_parity(fifo_rdata), fifo_rdata};
`else
    assign tx_load = fifo_rdata;
`endif
    assign tx_start_ok = !fifo_empty && !io.tx_hold;

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_sh_n    = tx_sh;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (tx_start_ok) begin
                    tx_pop     = 1'b1;
                    tx_sh_n    = tx_load;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                    tx_state_n = TX_DATA;
                end else tx_cnt_n = tx_cnt + 1'b1;
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    tx_sh_n  = tx_sh >> 1;
                    if (tx_idx == IDX_LAST) tx_state_n = TX_STOP;
                    else tx_idx_n = tx_idx + 1'b1;
                end else tx_cnt_n = tx_cnt + 1'b1;
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    // Chain straight into the next start bit so queued bytes go out gap-free.
                    if (tx_start_ok) begin
                        tx_pop     = 1'b1;
                        tx_sh_n    = tx_load;
                        tx_state_n = TX_START;
                    end else tx_state_n = TX_IDLE;
                end else tx_cnt_n = tx_cnt + 1'b1;
            end
            default: tx_state_n = TX_IDLE;
        endcase
        case (tx_state_n)
            TX_START: tx_line_n = 1'b0;
            TX_DATA:  tx_line_n = tx_sh_n[0];
            default:  tx_line_n = 1'b1;
        endcase
    end

    // A set/increment event in the same cycle as clr_status takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_byte <= '0;
            rx_count  <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_push) begin
                last_byte <= rx_sh[UART_DATA_BITS-1:0];
                rx_count  <= io.clr_status ? CNT_W'(1) : rx_count + 1'b1;
            end else if (io.clr_status) begin
                rx_count <= '0;
            end
            overflow  <= (rx_push && fifo_full && !tx_pop) || (overflow && !io.clr_status);
            frame_err <= frame_set || (frame_err && !io.clr_status);
        end
    end

`ifdef UART_ECHO_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err <= 1'b0;
        else        parity_err <= parity_set || (parity_err && !io.clr_status);
    end
    assign io.parity_err = parity_err;
`else
    assign io.parity_err = 1'b0;
`endif

    assign io.tx_serial  = tx_line;
    assign io.last_byte  = last_byte;
    assign io.rx_count   = rx_count;
    assign io.fifo_level = fifo_level;
    assign io.overflow   = overflow;
    assign io.frame_err  = frame_err;

endmodule

// File: doc/uart_echo_buffered.md
Name: uart_echo_buffered

Overview:
Self-contained UART loopback engine with a receiver, a transmitter and a parametrised FIFO between them.
- Received bytes are buffered and re-transmitted in order, with flow-control hold, sticky error flags and a byte counter.
- Replaces the unbuffered RX-to-TX echo; last_byte feeds the existing 7-segment debug display.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
DEPTH, 16, FIFO entries; power of two, >= 2.
CNT_W, 16, width of rx_count.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous, active-low reset.
rx_serial  in  1  async serial input, idle high.
tx_serial  out  1  serial output, idle high.
tx_hold  in  1  while high, TX starts no new frame; a frame in progress completes.
clr_status  in  1  synchronous clear of overflow, frame_err, parity_err and rx_count.
last_byte  out  8  most recent correctly framed RX byte.
rx_count  out  CNT_W  count of correctly framed RX bytes; wraps.
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
overflow  out  1  sticky: byte dropped because the FIFO was full.
frame_err  out  1  sticky: stop bit sampled low.
parity_err  out  1  sticky parity mismatch; tied 0 without the optional feature.

Behaviour:
- Reset (asynchronous, active-low):
  - tx_serial=1; last_byte=0; rx_count=0; fifo_level=0; all flags=0.
  - Both FSMs go to IDLE and the FIFO is emptied.
  - Reset asserted mid-frame aborts that frame. tx_serial returns high immediately.
- Input sync: rx_serial passes through a 2-FF synchroniser, reset value 1.
- Frame format: 8N1, LSB first.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE -> START when the synced line is low.
  - START: at CLKS_PER_BIT/2 cycles, re-sample. Line high -> IDLE (glitch reject). Line low -> DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Stop bit high: one-cycle push strobe; last_byte updated; rx_count+1; -> IDLE.
    - Stop bit low: frame_err set; byte discarded; -> WAIT_HIGH.
  - WAIT_HIGH -> IDLE once the synced line is high. This prevents a break condition from retriggering reception.
- FIFO rules:
  - Push on strobe.
  - If full and no pop in the same cycle: byte dropped, overflow set. last_byte and rx_count still update.
  - Push and pop in the same cycle: both occur; level unchanged.
  - Full and pop in the same cycle: push is accepted.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE pops when FIFO non-empty and tx_hold=0.
  - START: tx_serial=0.
  - DATA: 8 bits, LSB first.
  - STOP: tx_serial=1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - After STOP, TX may pop the next byte immediately (no extra idle bit).
- Latency: push strobe at cycle N with an empty FIFO and TX idle -> pop at N+1 -> tx_serial low from N+2.
- clr_status: clears flags and rx_count. If a set or increment event occurs in the same cycle, the event wins (flag=1, rx_count=1).
- rx_count wraps from 2^CNT_W-1 to 0.

Optional Feature:
UART_ECHO_PARITY_EN
- Defined:
  - An even-parity bit is inserted between data and stop on both RX and TX (11-bit frame).
  - RX parity mismatch sets parity_err. The byte is discarded: no push, no rx_count or last_byte update.
  - Stop-bit checking is unchanged.
- Undefined: 8N1 only; parity_err is constant 0.

Decomposition:
- Package uart_pkg holds:
  - enums uart_rx_state_e and uart_tx_state_e;
  - localparam UART_DATA_BITS=8;
  - localparam UART_DEFAULT_CLKS_PER_BIT=434.
- Sub-module uart_sync_fifo (DEPTH and width parameters; push, pop, full, empty, level). It is reusable elsewhere.
- RX and TX FSMs stay in the top module.

Test Plan (CLKS_PER_BIT=8, DEPTH=4 unless stated):
1. Send 0x41 -> tx_serial emits 0x41 with start bit low 2 cycles after the push strobe; last_byte=0x41; rx_count=1; fifo_level returns to 0.
2. tx_hold=1, send 0x30..0x35 -> fifo_level=4, overflow=1, last_byte=0x35, rx_count=6. Release tx_hold -> 0x30..0x33 echoed back-to-back with no idle gap.
3. Frame 0x55 with stop bit 0, line held low 3 bit-times -> no echo; frame_err=1; rx_count unchanged. Next valid 0xA5 -> echoed 0xA5.
4. 2-cycle low glitch on rx_serial -> no strobe, RX back in IDLE, tx_serial stays 1. clr_status pulsed together with a valid stop -> rx_count=1.
5. Assert rst_n=0 mid-TX-DATA of 0xF0 -> tx_serial=1 immediately; FIFO empty; no residual frame after release.
6. With UART_ECHO_PARITY_EN: send 0x07 with odd (wrong) parity bit -> parity_err=1, no echo. Correct parity -> echoed frame carries parity bit 1.
